// File: rtl/dsc_mem_pkg.sv
// Shared memory-block constants and width rules.
// Keeps the RAM and its controllers on the same defaults.
package dsc_mem_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 3;

    // Counters carry one extra bit so that 0..DEPTH is representable.
    function automatic int CNT_W(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Push/pop valid-ready bundle for ram_fifo_ctrl.
// The slave modport is the FIFO side; master is the user side.
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 32
);

    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  out_valid_o;
    logic                  out_ready_i;

    modport slave (
        input  in_data_i,
        input  in_valid_i,
        output in_ready_o,
        output out_data_o,
        output out_valid_o,
        input  out_ready_i
    );

    modport master (
        output in_data_i,
        output in_valid_i,
        input  in_ready_o,
        input  out_data_o,
        input  out_valid_o,
        output out_ready_i
    );

endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM: synchronous write, combinational read.
// Contents are never reset; rst_n only blocks writes while low.
module dual_port_ram
    import dsc_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  read_en_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (write_en_i && rst_n) begin
            r_mem[write_addr_i] <= data_i;
        end
    end

    assign data_o = read_en_i ? r_mem[read_addr_i] : '0;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller around dual_port_ram.
// Wrap-bit pointers give count, full and empty without extra state.
module ram_fifo_ctrl
    import dsc_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int AFULL_LEVEL = (2**ADDR_WIDTH) - 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    ram_fifo_ctrl_if.slave                 bus,
    output logic [CNT_W(ADDR_WIDTH)-1:0]   count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           almost_full_o,
    output logic                           ovf_o,
    output logic                           udf_o
);

    localparam int CW = CNT_W(ADDR_WIDTH);

    logic [CW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_rd_ptr;
    logic                  r_ovf;
    logic                  r_udf;
    logic [CW-1:0]         w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0])
                  && (r_wr_ptr[CW-1] != r_rd_ptr[CW-1]);
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_push  = bus.in_valid_i & ~w_full;
    assign w_pop   = bus.out_ready_i & ~w_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + CW'(1);
            if (bus.in_valid_i && w_full)   r_ovf <= 1'b1;
            if (bus.out_ready_i && w_empty) r_udf <= 1'b1;
        end
    end

    // Flush does not gate the write: the slot is unreachable once pointers clear.
    dual_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk          (clk),
        .rst_n        (~rst),
        .write_en_i   (w_push),
        .write_addr_i (r_wr_ptr[ADDR_WIDTH-1:0]),
        .data_i       (bus.in_data_i),
        .read_en_i    (1'b1),
        .read_addr_i  (r_rd_ptr[ADDR_WIDTH-1:0]),
        .data_o       (w_rd_data)
    );

    assign bus.in_ready_o  = ~w_full;
    assign bus.out_valid_o = ~w_empty;
    assign bus.out_data_o  = w_empty ? '0 : w_rd_data;
    assign count_o         = w_count;
    assign full_o          = w_full;
    assign empty_o         = w_empty;
    assign almost_full_o   = (w_count >= CW'(AFULL_LEVEL));
    assign ovf_o           = r_ovf;
    assign udf_o           = r_udf;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl (DEPTH=8) against a queue model.
// Directed scenarios followed by a randomized run.
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       afull;
    logic       ovf;
    logic       udf;

    int checks;
    int fails;

    logic [31:0] q[$];
    bit          m_ovf;
    bit          m_udf;

    ram_fifo_ctrl_if #(.DATA_WIDTH(32)) bus ();

    ram_fifo_ctrl #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (3),
        .AFULL_LEVEL (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .bus           (bus),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (afull),
        .ovf_o         (ovf),
        .udf_o         (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {count, empty, full, afull, ovf, udf, out_valid, in_ready, out_data}
    function automatic logic [42:0] exp_vec();
        int n;
        logic [31:0] h;
        n = q.size();
        h = (n != 0) ? q[0] : 32'h0;
        return {4'(n), n == 0, n == 8, n >= 6, m_ovf, m_udf,
                n != 0, n != 8, h};
    endfunction

    function automatic logic [42:0] obs_vec();
        return {count, empty, full, afull, ovf, udf,
                bus.out_valid_o, bus.in_ready_o, bus.out_data_o};
    endfunction

    task automatic model_clear();
        q.delete();
        m_ovf = 0;
        m_udf = 0;
    endtask

    // Drive one cycle, advance the model from pre-edge state, settle 1ns.
    task automatic cycle(input bit v, input logic [31:0] d,
                         input bit r, input bit f);
        int  n;
        bit  do_push;
        bit  do_pop;
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.out_ready_i = r;
        flush           = f;
        n = q.size();
        if (f) begin
            model_clear();
        end else begin
            do_push = v && (n != 8);
            do_pop  = r && (n != 0);
            if (v && n == 8) m_ovf = 1;
            if (r && n == 0) m_udf = 1;
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        @(posedge clk);
        #1;
        bus.in_valid_i  = 0;
        bus.out_ready_i = 0;
        flush           = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        flush = 0;
        bus.in_valid_i = 0;
        bus.out_ready_i = 0;
        bus.in_data_i = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL reset_state got=%h exp=%h", obs_vec(), exp_vec());
            fails++;
        end
        cycle(0, 32'h0, 0, 0);
        checks++;
        if (empty !== 1'b1 || bus.in_ready_o !== 1'b1 || count !== 4'd0
            || bus.out_data_o !== 32'h0) begin
            $display("FAIL reset_idle got=%h exp=%h", obs_vec(), exp_vec());
            fails++;
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cycle(1, 32'h10 + i, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL fill_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
                fails++;
            end
        end
        checks++;
        if (full !== 1'b1 || afull !== 1'b1) begin
            $display("FAIL fill_full got full=%b afull=%b exp 1 1", full, afull);
            fails++;
        end
        cycle(1, 32'h99, 0, 0);
        checks++;
        if (ovf !== 1'b1 || count !== 4'd8) begin
            $display("FAIL fill_ovf got ovf=%b count=%0d exp 1 8", ovf, count);
            fails++;
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.out_data_o !== 32'h10 + i) begin
                $display("FAIL drain_head_%0d got=%h exp=%h",
                         i, bus.out_data_o, 32'h10 + i);
                fails++;
            end
            cycle(0, 32'h0, 1, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL drain_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
                fails++;
            end
        end
        cycle(0, 32'h0, 1, 0);
        checks++;
        if (udf !== 1'b1 || empty !== 1'b1) begin
            $display("FAIL drain_udf got udf=%b empty=%b exp 1 1", udf, empty);
            fails++;
        end
    endtask

    task automatic test_wrap();
        cycle(0, 32'h0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 32'h100 + i, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 32'h0, 1, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(1, 32'h200 + i, 1, 0);
            checks++;
            if (obs_vec() !== exp_vec() || count !== 4'd1
                || bus.out_data_o !== 32'h200 + i) begin
                $display("FAIL wrap_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
                fails++;
            end
        end
        cycle(0, 32'h0, 1, 0);
    endtask

    task automatic test_simul();
        for (int i = 0; i < 8; i++) cycle(1, 32'h300 + i, 0, 0);
        cycle(1, 32'h3FF, 1, 0);
        checks++;
        if (obs_vec() !== exp_vec() || count !== 4'd7
            || bus.out_data_o !== 32'h301 || ovf !== 1'b1) begin
            $display("FAIL simul_full got=%h exp=%h", obs_vec(), exp_vec());
            fails++;
        end
        cycle(0, 32'h0, 0, 1);
        cycle(1, 32'h3AA, 1, 0);
        checks++;
        if (obs_vec() !== exp_vec() || count !== 4'd1
            || bus.out_data_o !== 32'h3AA || udf !== 1'b1) begin
            $display("FAIL simul_empty got=%h exp=%h", obs_vec(), exp_vec());
            fails++;
        end
    endtask

    task automatic to_four_with_ovf();
        cycle(0, 32'h0, 0, 1);
        for (int i = 0; i < 9; i++) cycle(1, 32'h400 + i, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 0);
    endtask

    task automatic test_flush_rst();
        to_four_with_ovf();
        checks++;
        if (count !== 4'd4 || ovf !== 1'b1) begin
            $display("FAIL flush_pre got count=%0d ovf=%b exp 4 1", count, ovf);
            fails++;
        end
        cycle(1, 32'h555, 1, 1);
        checks++;
        if (obs_vec() !== exp_vec() || count !== 4'd0 || ovf !== 1'b0) begin
            $display("FAIL flush_clear got=%h exp=%h", obs_vec(), exp_vec());
            fails++;
        end
        cycle(1, 32'hAB, 0, 0);
        checks++;
        if (bus.out_data_o !== 32'hAB || count !== 4'd1) begin
            $display("FAIL flush_ab got=%h exp=%h", bus.out_data_o, 32'hAB);
            fails++;
        end
        to_four_with_ovf();
        bus.in_valid_i = 1;
        bus.in_data_i  = 32'h666;
        #2;
        rst = 1;
        model_clear();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            $display("FAIL rst_async got=%h exp=%h", obs_vec(), exp_vec());
            fails++;
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 0;
        rst = 0;
        cycle(1, 32'hAB, 0, 0);
        checks++;
        if (obs_vec() !== exp_vec() || bus.out_data_o !== 32'hAB) begin
            $display("FAIL rst_ab got=%h exp=%h", obs_vec(), exp_vec());
            fails++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL random_%0d got=%h exp=%h", i, obs_vec(), exp_vec());
                fails++;
            end
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_flush_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
